branch_sequencer: RTL and testbench

Multi-cycle branch resolution unit for the 32-bit RISC-V core. It accepts one B-type instruction word with its PC and fetches rs1/rs2 through a shared, arbitrated register-file read port. It evaluates the branch condition selected by funct3 and returns the next PC plus taken, illegal and misaligned flags over a valid/ready handshake. It sits between decode and fetch redirect and owns the sequencing of the B-type field split and the immediate reassembly.

---
 rtl/branch_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_branch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Branch resolution unit for RV32 B-type instructions.
// Accepts one instruction/PC pair, reads rs1/rs2 through a shared register-file
// port, evaluates the funct3 condition and presents next PC and status flags.
module branch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        rf_req,
    output logic [4:0]  rf_addr,
    input  logic        rf_gnt,
    input  logic [31:0] rf_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        taken,
    output logic [31:0] next_pc,
    output logic        illegal,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        EVAL = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Instruction fields and operands captured at accept
    logic               bad_q;
    logic [2:0]         funct3_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic signed [31:0] imm_q;
    logic [31:0]        pc_q;
    logic signed [31:0] op1;
    logic signed [31:0] op2;

    // Decode of the incoming word, only meaningful on the accept cycle
    logic               dec_bad;
    logic [4:0]         dec_rs1;
    logic [4:0]         dec_rs2;
    logic               accept;
    logic [31:0]        target;
    logic               cond;
    logic               take;

    // Opcode must be BRANCH; funct3 010/011 have no defined branch.
    function automatic logic is_illegal(input logic [6:0] opcode, input logic [2:0] f3);
        return (opcode != 7'b1100011) || (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // Reassemble the scattered B-type immediate and sign-extend from bit 12.
    function automatic logic signed [31:0] b_imm(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    // Branch condition selected by funct3; illegal encodings evaluate false.
    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic signed [31:0] a,
                                         input logic signed [31:0] b);
        logic [31:0] ua;
        logic [31:0] ub;
        ua = a;
        ub = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return a < b;
            3'b101:  return a >= b;
            3'b110:  return ua < ub;
            3'b111:  return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    assign dec_bad = is_illegal(instr[6:0], instr[14:12]);
    assign dec_rs1 = instr[19:15];
    assign dec_rs2 = instr[24:20];
    assign accept  = in_valid && in_ready;
    assign target  = pc_q + imm_q;
    assign cond    = branch_cond(funct3_q, op1, op2);
    assign take    = !bad_q && cond;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake/read-port outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rf_req    = 1'b0;
        rf_addr   = 5'd0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (accept) begin
                    if (dec_bad || (dec_rs1 == 5'd0 && dec_rs2 == 5'd0)) begin
                        state_nxt = EVAL;
                    end else if (dec_rs1 != 5'd0) begin
                        state_nxt = RD1;
                    end else begin
                        state_nxt = RD2;
                    end
                end
            end
            RD1: begin
                rf_req  = 1'b1;
                rf_addr = rs1_q;
                if (rf_gnt) begin
                    state_nxt = (rs2_q != 5'd0) ? RD2 : EVAL;
                end
            end
            RD2: begin
                rf_req  = 1'b1;
                rf_addr = rs2_q;
                if (rf_gnt) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                state_nxt = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture fields on accept; operands default to x0 and fill on grants
    always_ff @(posedge clk) begin
        if (accept) begin
            bad_q    <= dec_bad;
            funct3_q <= instr[14:12];
            rs1_q    <= dec_rs1;
            rs2_q    <= dec_rs2;
            imm_q    <= b_imm(instr);
            pc_q     <= pc;
            op1      <= '0;
            op2      <= '0;
        end else if (state == RD1 && rf_gnt) begin
            op1 <= rf_rdata;
        end else if (state == RD2 && rf_gnt) begin
            op2 <= rf_rdata;
        end
    end

    // Result registers, loaded in EVAL and held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            taken      <= 1'b0;
            next_pc    <= '0;
            illegal    <= 1'b0;
            misaligned <= 1'b0;
        end else if (state == EVAL) begin
            taken      <= take;
            next_pc    <= take ? target : pc_q + 32'd4;
            illegal    <= bad_q;
            misaligned <= take && (target[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Testbench for branch_sequencer: directed cases followed by random
// instructions checked against a behavioural model of the branch rules.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rf_req;
    logic [4:0]  rf_addr;
    logic        rf_gnt;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] next_pc;
    logic        illegal;
    logic        misaligned;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] regs [32];

    branch_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc),
        .rf_req(rf_req), .rf_addr(rf_addr), .rf_gnt(rf_gnt), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .next_pc(next_pc), .illegal(illegal), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural model: expected result and the ordered list of register reads.
    task automatic model(input logic [31:0] w, input logic [31:0] p,
                         output logic e_tk, output logic [31:0] e_npc,
                         output logic e_ill, output logic e_mis,
                         output int nr, output logic [4:0] addrs [2]);
        longint imm;
        longint a;
        longint b;
        longint ua;
        longint ub;
        int rs1;
        int rs2;
        int f3;
        logic [31:0] tgt;
        f3  = int'(w[14:12]);
        rs1 = int'(w[19:15]);
        rs2 = int'(w[24:20]);
        imm = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0)
              + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        e_ill = (w[6:0] != 7'b1100011) || f3 == 2 || f3 == 3;
        ua = longint'(regs[rs1]);
        ub = longint'(regs[rs2]);
        if (rs1 == 0) ua = 0;
        if (rs2 == 0) ub = 0;
        a = (ua >= 64'h8000_0000) ? ua - 64'h1_0000_0000 : ua;
        b = (ub >= 64'h8000_0000) ? ub - 64'h1_0000_0000 : ub;
        case (f3)
            0: e_tk = (a == b);
            1: e_tk = (a != b);
            4: e_tk = (a < b);
            5: e_tk = (a >= b);
            6: e_tk = (ua < ub);
            7: e_tk = (ua >= ub);
            default: e_tk = 1'b0;
        endcase
        if (e_ill) e_tk = 1'b0;
        tgt   = 32'(longint'(p) + imm);
        e_npc = e_tk ? tgt : p + 32'd4;
        e_mis = e_tk && (tgt % 4 != 0);
        nr = 0;
        addrs[0] = 5'd0;
        addrs[1] = 5'd0;
        if (!e_ill) begin
            if (rs1 != 0) begin addrs[nr] = 5'(rs1); nr++; end
            if (rs2 != 0) begin addrs[nr] = 5'(rs2); nr++; end
        end
    endtask

    // One full transaction: accept, serve reads with d1/d2 denied cycles,
    // check result and latency, hold out_ready low for hold cycles, then retire.
    task automatic run(input string tag, input logic [31:0] w, input logic [31:0] p,
                       input int d1, input int d2, input int hold);
        logic e_tk, e_ill, e_mis;
        logic [31:0] e_npc;
        int nr, rd_idx, lat, exp_lat, deny_left;
        logic [4:0] addrs [2];
        logic [4:0] held_addr;
        logic prev_denied;
        logic done;
        logic [31:0] s_npc;
        logic s_tk;
        model(w, p, e_tk, e_npc, e_ill, e_mis, nr, addrs);
        exp_lat = 2 + nr + (nr > 0 ? d1 : 0) + (nr > 1 ? d2 : 0);
        @(negedge clk);
        in_valid = 1'b1;
        instr = w;
        pc = p;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instr = $urandom;
        pc = $urandom;
        lat = 1;
        rd_idx = 0;
        deny_left = d1;
        prev_denied = 1'b0;
        held_addr = '0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (prev_denied) begin
                check({tag, ".req_hold"}, 32'(rf_req), 32'd1);
                check({tag, ".addr_hold"}, 32'(rf_addr), 32'(held_addr));
            end
            prev_denied = 1'b0;
            if (!rf_req) check({tag, ".addr_idle"}, 32'(rf_addr), 32'd0);
            if (out_valid) begin
                done = 1'b1;
                rf_gnt = 1'b0;
            end else begin
                if (rf_req) begin
                    if (deny_left > 0) begin
                        rf_gnt = 1'b0;
                        rf_rdata = $urandom;
                        deny_left--;
                        prev_denied = 1'b1;
                        held_addr = rf_addr;
                    end else begin
                        if (rd_idx < nr) check({tag, ".rf_addr"}, 32'(rf_addr), 32'(addrs[rd_idx]));
                        else check({tag, ".extra_read"}, 32'(rd_idx), 32'(nr - 1));
                        rf_gnt = 1'b1;
                        rf_rdata = regs[rf_addr];
                        rd_idx++;
                        deny_left = d2;
                    end
                end else begin
                    rf_gnt = 1'($urandom);
                    rf_rdata = $urandom;
                end
                @(posedge clk);
                lat++;
            end
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".reads"}, 32'(rd_idx), 32'(nr));
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".taken"}, 32'(taken), 32'(e_tk));
        check({tag, ".next_pc"}, next_pc, e_npc);
        check({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
        check({tag, ".misaligned"}, 32'(misaligned), 32'(e_mis));
        s_npc = next_pc;
        s_tk = taken;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            rf_gnt = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_npc"}, next_pc, s_npc);
            check({tag, ".hold_taken"}, 32'(taken), 32'(s_tk));
        end
        out_ready = 1'b1;
        rf_gnt = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".retired"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [4:0] r1, r2;
        logic [31:0] vals [5];
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rf_gnt = 1'b0;
        rf_rdata = '0;
        instr = '0;
        pc = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.rf_req", 32'(rf_req), 32'd0);
        check("rst.rf_addr", 32'(rf_addr), 32'd0);
        check("rst.taken", 32'(taken), 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);
        check("rst.misaligned", 32'(misaligned), 32'd0);
        check("rst.next_pc", next_pc, 32'd0);
        rst = 1'b0;

        // Directed cases
        regs[1] = 32'd5; regs[2] = 32'd5;
        regs[3] = 32'hFFFF_FFFF; regs[4] = 32'd1;
        run("beq", 32'h0020_8463, 32'h100, 0, 0, 0);
        run("blt", 32'hFE41_CEE3, 32'h200, 0, 0, 0);
        run("bltu", 32'hFE41_EEE3, 32'h200, 0, 0, 0);
        run("wrap_x0", 32'h0000_0463, 32'hFFFF_FFFC, 0, 0, 0);
        run("ill_f3", 32'h0020_A463, 32'h300, 0, 0, 0);
        run("ill_op", 32'h0020_8433, 32'h304, 0, 0, 0);
        run("misalign", 32'h0000_0163, 32'h400, 0, 0, 0);
        run("rd1_deny", 32'h0020_8463, 32'h100, 3, 0, 0);
        run("rs1_zero", 32'h0010_0463, 32'h500, 0, 2, 0);
        run("out_hold", 32'hFE41_CEE3, 32'h200, 1, 1, 5);

        // Reset while waiting in RD2
        @(negedge clk);
        in_valid = 1'b1;
        instr = 32'h0020_8463;
        pc = 32'h100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rf_req && rf_addr == 5'd2) break;
            rf_gnt = rf_req;
            rf_rdata = regs[rf_addr];
            @(posedge clk);
        end
        check("mid.in_rd2", 32'(rf_addr), 32'd2);
        rf_gnt = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid.rf_req", 32'(rf_req), 32'd0);
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.in_ready_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid.in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid.no_pulse", 32'(out_valid), 32'd0);
        end
        run("post_rst_beq", 32'h0020_8463, 32'h100, 0, 0, 0);

        // Random instructions against the model
        vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'hFFFF_FFFF;
        vals[3] = 32'h8000_0000; vals[4] = 32'h7FFF_FFFF;
        for (int i = 5; i < 10; i++) regs[i] = vals[$urandom_range(0, 4)];
        for (int n = 0; n < 80; n++) begin
            w = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(5, 9));
            r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(5, 9));
            w[19:15] = r1;
            w[24:20] = r2;
            if ($urandom_range(0, 9) != 0) w[6:0] = 7'b1100011;
            if (n % 16 == 0) begin
                for (int i = 5; i < 10; i++) regs[i] = ($urandom_range(0, 1) != 0) ? $urandom : vals[$urandom_range(0, 4)];
            end
            run("rand", w, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
